// File: rtl/sample_queue.sv
// sample_queue: circular stereo sample buffer that streams all DEPTH samples oldest-first to the FIR on each new sample once full
module sample_queue #(
    parameter int DEPTH = 1021,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_smpl,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rht_smpl,
    output logic        sequencing,
    output logic [15:0] lft_out,
    output logic [15:0] rht_out
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, READ} state_t;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_new_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_rd_cnt;
    logic [AW:0]   r_fill;
    logic          w_wr;
    logic [AW-1:0] w_nxt;
    logic [AW:0]   w_fill_nxt;

    // samples arriving while a burst is still being issued or shown are dropped
    assign w_wr       = wrt_smpl && r_state == IDLE && !sequencing;
    assign w_nxt      = (r_new_ptr == LAST) ? '0 : r_new_ptr + AW'(1);
    assign w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + (AW + 1)'(1);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_new_ptr] <= {lft_smpl, rht_smpl};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_new_ptr  <= '0;
            r_rd_ptr   <= '0;
            r_rd_cnt   <= '0;
            r_fill     <= '0;
            sequencing <= 1'b0;
            lft_out    <= '0;
            rht_out    <= '0;
        end else begin
            if (w_wr) begin
                r_new_ptr <= w_nxt;
                r_fill    <= w_fill_nxt;
            end
            if (r_state == IDLE) begin
                sequencing <= 1'b0;
                if (w_wr && w_fill_nxt == FULL) begin
                    r_state  <= READ;
                    r_rd_ptr <= w_nxt;
                    r_rd_cnt <= '0;
                end
            end else begin
                // the RAM read register doubles as the output stage, keeping data and sequencing aligned
                sequencing         <= 1'b1;
                {lft_out, rht_out} <= r_mem[r_rd_ptr];
                r_rd_ptr           <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
                r_rd_cnt           <= r_rd_cnt + AW'(1);
                if (r_rd_cnt == LAST) r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sample_queue.sv
// tb_sample_queue: directed bench for sample_queue at DEPTH=5 and the default DEPTH=1021
module tb_sample_queue;
    logic        clk = 1'b0;
    logic        rst_s, rst_b, sel, wrt;
    logic [15:0] lin, rin;
    logic        s_seq, b_seq, seq;
    logic [15:0] s_lft, s_rht, b_lft, b_rht, lo, ro;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sample_queue #(.DEPTH(5), .AW(3)) u_small (
        .clk(clk), .rst_n(rst_s), .wrt_smpl(wrt && !sel), .lft_smpl(lin), .rht_smpl(rin),
        .sequencing(s_seq), .lft_out(s_lft), .rht_out(s_rht)
    );

    sample_queue u_big (
        .clk(clk), .rst_n(rst_b), .wrt_smpl(wrt && sel), .lft_smpl(lin), .rht_smpl(rin),
        .sequencing(b_seq), .lft_out(b_lft), .rht_out(b_rht)
    );

    assign seq = sel ? b_seq : s_seq;
    assign lo  = sel ? b_lft : s_lft;
    assign ro  = sel ? b_rht : s_rht;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int k);
        wrt = 1'b1;
        lin = 16'(k);
        rin = 16'(-k);
        tick();
        wrt = 1'b0;
    endtask

    task automatic check_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (seq !== 1'b0) begin
                errors++;
                $display("FAIL %s: sequencing=%b expected 0 (cycle %0d)", name, seq, i);
            end
        end
    endtask

    task automatic fill(input int start, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            wrt = 1'b1;
            lin = 16'(start + i);
            rin = 16'(-(start + i));
            tick();
            checks++;
            if (seq !== 1'b0) begin
                errors++;
                $display("FAIL %s: sequencing=%b expected 0 after write %0d", name, seq, i);
            end
        end
        wrt = 1'b0;
    endtask

    // call right after write(): expects the burst to show first..first+depth-1; coll marks cycles that also strobe 0x7FFF
    task automatic burst(input int first, input logic [31:0] coll, input string name);
        int depth;
        depth = sel ? 1021 : 5;
        checks++;
        if (seq !== 1'b0) begin
            errors++;
            $display("FAIL %s early: sequencing=%b expected 0 one cycle after strobe", name, seq);
        end
        for (int i = 0; i < depth; i++) begin
            tick();
            wrt = 1'b0;
            checks++;
            if (seq !== 1'b1 || lo !== 16'(first + i) || ro !== 16'(-(first + i))) begin
                errors++;
                $display("FAIL %s cycle %0d: seq=%b L=%h R=%h expected seq=1 L=%h R=%h",
                         name, i, seq, lo, ro, 16'(first + i), 16'(-(first + i)));
            end
            if (i < 32 && coll[i]) begin
                wrt = 1'b1;
                lin = 16'h7FFF;
                rin = 16'h7FFF;
            end
        end
        tick();
        wrt = 1'b0;
        checks++;
        if (seq !== 1'b0 || lo !== 16'(first + depth - 1)) begin
            errors++;
            $display("FAIL %s end: seq=%b L=%h expected seq=0 L=%h (held)",
                     name, seq, lo, 16'(first + depth - 1));
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            checks++;
            if (seq !== 1'b0 || lo !== 16'h0 || ro !== 16'h0) begin
                errors++;
                $display("FAIL reset dut%0d: seq=%b L=%h R=%h expected 0 0 0", d, seq, lo, ro);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        sel = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            write(k);
            check_idle(3, "fill_partial");
        end
        write(5);
        burst(1, 32'h0, "fill_burst");
    endtask

    task automatic test_wrap();
        write(6);
        burst(2, 32'h0, "wrap_6");
        write(7);
        burst(3, 32'h0, "wrap_7");
    endtask

    task automatic test_collision();
        write(8);
        burst(4, 32'b10101, "collide_burst");
        write(9);
        burst(5, 32'h0, "after_collide");
    endtask

    task automatic test_reset_small();
        tick();
        #2;
        rst_s = 1'b0;
        #1;
        checks++;
        if (seq !== 1'b0 || lo !== 16'h0 || ro !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_small: seq=%b L=%h R=%h expected 0 0 0", seq, lo, ro);
        end
        @(negedge clk);
        rst_s = 1'b1;
        tick();
        for (int k = 11; k <= 14; k++) begin
            write(k);
            check_idle(2, "refill_small");
        end
        write(15);
        burst(11, 32'h0, "refill_burst");
    endtask

    task automatic test_default_depth();
        sel = 1'b1;
        fill(1, 1020, "big_fill");
        write(1021);
        burst(1, 32'h0, "big_first");
        write(1022);
        burst(2, 32'h0, "big_wrap");
    endtask

    task automatic test_reset_mid_burst();
        sel = 1'b1;
        write(1023);
        repeat (100) tick();
        checks++;
        if (seq !== 1'b1 || lo !== 16'd102) begin
            errors++;
            $display("FAIL mid_burst_pre: seq=%b L=%h expected seq=1 L=%h", seq, lo, 16'd102);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (seq !== 1'b0 || lo !== 16'h0 || ro !== 16'h0) begin
            errors++;
            $display("FAIL mid_burst_reset: seq=%b L=%h R=%h expected 0 0 0", seq, lo, ro);
        end
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        fill(2001, 1020, "post_reset_fill");
        write(3021);
        burst(2001, 32'h0, "post_reset_burst");
    endtask

    initial begin
        rst_s = 1'b0;
        rst_b = 1'b0;
        wrt   = 1'b0;
        lin   = '0;
        rin   = '0;
        sel   = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_collision();
        test_reset_small();
        test_default_depth();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
